snake_tile_renderer: RTL and testbench
======================================

Name: snake_tile_renderer

Overview:
- Parametrised successor to the snake overlay path. Replaces the per-pixel 100-way segment compare with a per-frame tile occupancy build.
- The build starts at frame end (screen_end) and walks the segment list sequentially into a back-buffer bitmap, then swaps buffers so the display never tears.
- The pixel side is a 2-stage pipeline that looks up the front buffer and muxes head/body/dead colours over the background image colour.
- Sits between VGATimingGenerator / palette RAM and the VGA_R/G/B outputs.

Parameters:
GRID_W, 10, tile columns
GRID_H, 10, tile rows
TILE, 40, tile edge in pixels
X0, 48, pixel x of grid left edge
Y0, 48, pixel y of grid top edge
MAX_SEG, 100, segment slots in seg_x/seg_y
COORD_W, 32, bits per segment coordinate
HEAD_COLOR, 12'h0F0, colour of segment 0
BODY_COLOR, 12'h080, colour of segments 1..MAX_SEG-1
DEAD_COLOR, 12'hF00, body/head colour while game_done=1

Ports:
clk25  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
seg_x  in  MAX_SEG*COORD_W  segment tile columns; slot i at [COORD_W*i +: COORD_W]; all-ones = unused
seg_y  in  MAX_SEG*COORD_W  segment tile rows, same packing
game_done  in  1  selects DEAD_COLOR for snake pixels
screen_end  in  1  one-cycle pulse between frames; starts a build
x  in  32  current pixel column
y  in  32  current pixel row
active  in  1  visible-region flag aligned with x/y
bg_color  in  12  background colour, aligned with x/y
color_out  out  12  final pixel colour, 2-cycle latency
busy  out  1  high while a build is in progress
frame_drop  out  1  one-cycle pulse when screen_end arrives while busy
coord_err  out  1  sticky per build: a non-unused segment was out of grid

Behaviour:
- Reset (reset=0 at a clk25 edge): FSM to IDLE. Both bitmaps cleared. Pipeline registers cleared. color_out=0, busy=0, frame_drop=0, coord_err=0. Reset dominates all other inputs, including mid-build.
- Each bitmap holds GRID_H rows x GRID_W cells x 2 bits: {occupied, head}. The front select bit picks the displayed bitmap.
- FSM states: IDLE, CLEAR, LOAD, SWAP.
  - IDLE: screen_end=1 -> CLEAR. row_idx=0, busy=1, coord_err=0.
  - CLEAR: zeroes one back-buffer row per cycle. After row GRID_H-1 -> LOAD with seg_idx=0. Takes GRID_H cycles.
  - LOAD: processes one segment per cycle.
    - Slot with x or y equal to all-ones: skipped.
    - Slot with x>=GRID_W or y>=GRID_H: skipped, coord_err<=1.
    - Otherwise sets occupied for that cell. Sets head if seg_idx==0.
    - Head bit is never cleared by a later body segment at the same cell.
    - After seg_idx MAX_SEG-1 -> SWAP. Takes MAX_SEG cycles.
  - SWAP: toggles front select, busy<=0, -> IDLE. Takes 1 cycle.
  - Total build: GRID_H+MAX_SEG+1 cycles.
- seg_x/seg_y must be held stable from screen_end until busy falls. This is the caller's contract and is not checked.
- screen_end while busy: ignored; the build continues and frame_drop pulses for 1 cycle. The next frame then shows the previous bitmap until SWAP.
- Pixel pipeline:
  - Stage 1 registers: in_grid, col, row, active, bg_color.
    - in_grid = X0<=x<X0+GRID_W*TILE and Y0<=y<Y0+GRID_H*TILE.
    - col and row come from a compare chain against X0+k*TILE and Y0+k*TILE. No divider.
  - Stage 2 registers color_out:
    - active_d=0 -> 0.
    - in_grid, occupied and game_done -> DEAD_COLOR.
    - Else in_grid and head -> HEAD_COLOR.
    - Else in_grid and occupied -> BODY_COLOR.
    - Else -> bg_color_d.
- The stage-1 bitmap read uses the front buffer at that cycle. A swap mid-frame cannot occur when screen_end is the only trigger and the build completes before the first active line.
- Widths: x/y compared unsigned at 32 bits. Segment coordinates compared unsigned at COORD_W. All-ones is never a valid cell.

Test Plan:
- Reset held 3 cycles mid-LOAD -> busy=0, color_out=0; after release, pixel (68,68) active with bg 12'h123 -> 12'h123 two cycles later.
- Segment 0 at (0,0), segment 1 at (1,0), rest all-ones; pulse screen_end; wait 111 cycles.
  - busy high for exactly 111 cycles.
  - Pixel (50,50) -> 12'h0F0.
  - Pixel (90,50) -> 12'h080.
  - Pixel (130,50) -> bg.
  - Pixel (47,50) -> bg.
- Same snake with game_done=1 -> pixels (50,50) and (90,50) -> 12'hF00.
- Segment 3 at (10,2), default params -> coord_err=1 after build, no cell set; next build with a valid list -> coord_err=0.
- screen_end pulsed again 20 cycles into a build -> frame_drop=1 for one cycle, build length unchanged, single swap.
- Segments 0 and 5 both at (4,4) -> pixel (48+160,48+160) = 12'h0F0; active=0 at any pixel -> color_out=0 after 2 cycles.

Source files
------------

// File: rtl/snake_tile_renderer.sv
// Snake overlay: a per-frame tile bitmap is built into a back buffer, then the buffers swap.
// The pixel path is 2 stages (position decode + front-buffer read, then colour mux); it never stalls.
module snake_tile_renderer #(
  parameter int          GRID_W     = 10,
  parameter int          GRID_H     = 10,
  parameter int          TILE       = 40,
  parameter int          X0         = 48,
  parameter int          Y0         = 48,
  parameter int          MAX_SEG    = 100,
  parameter int          COORD_W    = 32,
  parameter logic [11:0] HEAD_COLOR = 12'h0F0,
  parameter logic [11:0] BODY_COLOR = 12'h080,
  parameter logic [11:0] DEAD_COLOR = 12'hF00
) (
  input  logic                       clk25,
  input  logic                       reset,
  input  logic [MAX_SEG*COORD_W-1:0] seg_x,
  input  logic [MAX_SEG*COORD_W-1:0] seg_y,
  input  logic                       game_done,
  input  logic                       screen_end,
  input  logic [31:0]                x,
  input  logic [31:0]                y,
  input  logic                       active,
  input  logic [11:0]                bg_color,
  output logic [11:0]                color_out,
  output logic                       busy,
  output logic                       frame_drop,
  output logic                       coord_err
);

  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int SEG_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;
  localparam logic [31:0] X_LO = 32'(X0);
  localparam logic [31:0] X_HI = 32'(X0 + GRID_W * TILE);
  localparam logic [31:0] Y_LO = 32'(Y0);
  localparam logic [31:0] Y_HI = 32'(Y0 + GRID_H * TILE);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, SWAP} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [SEG_W-1:0]   seg_idx_q, seg_idx_d;
  logic               busy_q, busy_d;
  logic               coord_err_q, coord_err_d;
  logic               front_q, front_d;
  logic               frame_drop_q, frame_drop_d;

  // Per buffer, per row: one bit per column for {occupied} and {head}.
  logic [GRID_W-1:0]  occ_q  [2][GRID_H];
  logic [GRID_W-1:0]  head_q [2][GRID_H];

  logic [COORD_W-1:0] seg_cx, seg_cy;
  logic               clr_en, set_en, set_head;
  logic               back;

  assign seg_cx = seg_x[seg_idx_q*COORD_W +: COORD_W];
  assign seg_cy = seg_y[seg_idx_q*COORD_W +: COORD_W];
  assign back   = ~front_q;

  always_ff @(posedge clk25) begin
    if (!reset) begin
      state_q      <= IDLE;
      row_idx_q    <= '0;
      seg_idx_q    <= '0;
      busy_q       <= 1'b0;
      coord_err_q  <= 1'b0;
      front_q      <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      seg_idx_q    <= seg_idx_d;
      busy_q       <= busy_d;
      coord_err_q  <= coord_err_d;
      front_q      <= front_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    seg_idx_d    = seg_idx_q;
    busy_d       = busy_q;
    coord_err_d  = coord_err_q;
    front_d      = front_q;
    frame_drop_d = screen_end && busy_q;
    clr_en       = 1'b0;
    set_en       = 1'b0;
    set_head     = 1'b0;
    case (state_q)
      IDLE: begin
        if (screen_end) begin
          state_d     = CLEAR;
          row_idx_d   = '0;
          busy_d      = 1'b1;
          coord_err_d = 1'b0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (row_idx_q == ROW_W'(GRID_H - 1)) begin
          state_d   = LOAD;
          seg_idx_d = '0;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
        end
      end
      LOAD: begin
        // All-ones in either coordinate marks an unused slot.
        if (!(&seg_cx) && !(&seg_cy)) begin
          if (seg_cx >= COORD_W'(GRID_W) || seg_cy >= COORD_W'(GRID_H)) begin
            coord_err_d = 1'b1;
          end else begin
            set_en   = 1'b1;
            set_head = (seg_idx_q == '0);
          end
        end
        if (seg_idx_q == SEG_W'(MAX_SEG - 1)) begin
          state_d = SWAP;
        end else begin
          seg_idx_d = seg_idx_q + 1'b1;
        end
      end
      SWAP: begin
        front_d = ~front_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bits are only ever set during LOAD, so a body segment cannot clear a head mark.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < GRID_H; r++) begin
          occ_q[b][r]  <= '0;
          head_q[b][r] <= '0;
        end
      end
    end else begin
      if (clr_en) begin
        occ_q[back][row_idx_q]  <= '0;
        head_q[back][row_idx_q] <= '0;
      end
      if (set_en) begin
        occ_q[back][seg_cy[ROW_W-1:0]][seg_cx[COL_W-1:0]] <= 1'b1;
        if (set_head) begin
          head_q[back][seg_cy[ROW_W-1:0]][seg_cx[COL_W-1:0]] <= 1'b1;
        end
      end
    end
  end

  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;
  logic             in_grid_c;

  // Tile index by compare chain against tile boundaries; thresholds rise monotonically.
  always_comb begin
    col_c = '0;
    row_c = '0;
    for (int k = 1; k < GRID_W; k++) begin
      if (x >= 32'(X0 + k * TILE)) col_c = COL_W'(k);
    end
    for (int k = 1; k < GRID_H; k++) begin
      if (y >= 32'(Y0 + k * TILE)) row_c = ROW_W'(k);
    end
    in_grid_c = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  end

  logic        in_grid_q, occ_s1_q, head_s1_q, active_s1_q;
  logic [11:0] bg_s1_q;
  logic [11:0] color_q, color_d;

  always_ff @(posedge clk25) begin
    if (!reset) begin
      in_grid_q   <= 1'b0;
      occ_s1_q    <= 1'b0;
      head_s1_q   <= 1'b0;
      active_s1_q <= 1'b0;
      bg_s1_q     <= '0;
      color_q     <= '0;
    end else begin
      in_grid_q   <= in_grid_c;
      occ_s1_q    <= occ_q[front_q][row_c][col_c];
      head_s1_q   <= head_q[front_q][row_c][col_c];
      active_s1_q <= active;
      bg_s1_q     <= bg_color;
      color_q     <= color_d;
    end
  end

  always_comb begin
    color_d = bg_s1_q;
    if (!active_s1_q)                             color_d = '0;
    else if (in_grid_q && occ_s1_q && game_done)  color_d = DEAD_COLOR;
    else if (in_grid_q && head_s1_q)              color_d = HEAD_COLOR;
    else if (in_grid_q && occ_s1_q)               color_d = BODY_COLOR;
  end

  assign color_out  = color_q;
  assign busy       = busy_q;
  assign frame_drop = frame_drop_q;
  assign coord_err  = coord_err_q;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed bench for snake_tile_renderer with default parameters.
module tb_snake_tile_renderer;

  localparam int MAX_SEG = 100;
  localparam int COORD_W = 32;

  logic                       clk25 = 1'b0;
  logic                       reset;
  logic [MAX_SEG*COORD_W-1:0] seg_x, seg_y;
  logic                       game_done, screen_end, active;
  logic [31:0]                x, y;
  logic [11:0]                bg_color, color_out;
  logic                       busy, frame_drop, coord_err;

  int total = 0;
  int bad   = 0;

  snake_tile_renderer dut (
    .clk25(clk25), .reset(reset), .seg_x(seg_x), .seg_y(seg_y),
    .game_done(game_done), .screen_end(screen_end), .x(x), .y(y),
    .active(active), .bg_color(bg_color), .color_out(color_out),
    .busy(busy), .frame_drop(frame_drop), .coord_err(coord_err)
  );

  always #20 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_segs();
    seg_x = '1;
    seg_y = '1;
  endtask

  task automatic set_seg(input int i, input int cx, input int cy);
    seg_x[i*COORD_W +: COORD_W] = COORD_W'(cx);
    seg_y[i*COORD_W +: COORD_W] = COORD_W'(cy);
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic act,
                     input logic [11:0] bg, input logic [11:0] exp);
    x = 32'(px);
    y = 32'(py);
    active = act;
    bg_color = bg;
    tick();
    tick();
    chk(tag, {20'd0, color_out}, {20'd0, exp});
  endtask

  // Pulses screen_end and counts sampled busy-high cycles until busy falls.
  task automatic build(output int cnt);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      tick();
    end
  endtask

  int n, fd_cnt;

  initial begin
    reset = 1'b0; game_done = 1'b0; screen_end = 1'b0; active = 1'b0;
    x = '0; y = '0; bg_color = '0;
    clear_segs();
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_color", {20'd0, color_out}, 32'd0);
    chk("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    chk("rst_coord_err", {31'd0, coord_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset in the middle of LOAD.
    set_seg(0, 0, 0);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    repeat (30) tick();
    chk("midload_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    x = 32'd68; y = 32'd68; active = 1'b1; bg_color = 12'h123;
    repeat (3) tick();
    chk("midload_rst_busy", {31'd0, busy}, 32'd0);
    chk("midload_rst_color", {20'd0, color_out}, 32'd0);
    reset = 1'b1;
    pix("post_rst_pixel", 68, 68, 1'b1, 12'h123, 12'h123);

    // Two-segment snake.
    clear_segs();
    set_seg(0, 0, 0);
    set_seg(1, 1, 0);
    build(n);
    chk("busy_len", 32'(n), 32'd111);
    chk("coord_err_clean", {31'd0, coord_err}, 32'd0);
    pix("head_px", 50, 50, 1'b1, 12'h5A5, 12'h0F0);
    pix("body_px", 90, 50, 1'b1, 12'h5A5, 12'h080);
    pix("empty_px", 130, 50, 1'b1, 12'h5A5, 12'h5A5);
    pix("left_edge_px", 47, 50, 1'b1, 12'h3C3, 12'h3C3);
    pix("bottom_out_px", 50, 448, 1'b1, 12'h321, 12'h321);

    game_done = 1'b1;
    pix("dead_head_px", 50, 50, 1'b1, 12'h5A5, 12'hF00);
    pix("dead_body_px", 90, 50, 1'b1, 12'h5A5, 12'hF00);
    pix("dead_empty_px", 130, 50, 1'b1, 12'h5A5, 12'h5A5);
    game_done = 1'b0;

    // Head and a later body segment on the same cell.
    clear_segs();
    set_seg(0, 4, 4);
    set_seg(5, 4, 4);
    build(n);
    pix("overlap_head_px", 208, 208, 1'b1, 12'h777, 12'h0F0);
    pix("inactive_px", 208, 208, 1'b0, 12'h777, 12'h000);
    pix("old_snake_gone_px", 50, 50, 1'b1, 12'h777, 12'h777);

    // Out-of-grid segment.
    clear_segs();
    set_seg(3, 10, 2);
    build(n);
    chk("coord_err_set", {31'd0, coord_err}, 32'd1);
    pix("oob_row2_col9_px", 413, 133, 1'b1, 12'h444, 12'h444);
    pix("oob_prev_cleared_px", 208, 208, 1'b1, 12'h444, 12'h444);

    clear_segs();
    set_seg(0, 0, 0);
    build(n);
    chk("coord_err_cleared", {31'd0, coord_err}, 32'd0);

    // Second screen_end 20 cycles into a build.
    clear_segs();
    set_seg(0, 2, 0);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    n = 0;
    fd_cnt = 0;
    while (busy && n < 400) begin
      n++;
      if (n == 20) screen_end = 1'b1;
      tick();
      if (n == 20) begin
        screen_end = 1'b0;
        chk("frame_drop_pulse", {31'd0, frame_drop}, 32'd1);
      end
      if (frame_drop) fd_cnt++;
    end
    chk("drop_busy_len", 32'(n), 32'd111);
    chk("drop_pulse_count", 32'(fd_cnt), 32'd1);
    tick();
    chk("drop_no_restart", {31'd0, busy}, 32'd0);
    pix("drop_new_head_px", 130, 50, 1'b1, 12'h246, 12'h0F0);
    pix("drop_old_head_px", 50, 50, 1'b1, 12'h246, 12'h246);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
